// File: rtl/mem_region_controller_if.sv
// CPU data port plus shared region-slave bus of mem_region_controller.
// The controller uses the slave modport; the CPU/slave environment uses master.
interface mem_region_controller_if #(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W      = 14
);
  logic [31:0]               CpuAddress;
  logic [1:0]                CpuSize;
  logic                      CpuSignExtend;
  logic                      CpuReadAssert;
  logic                      CpuWriteAssert;
  logic [31:0]               CpuWriteData;
  logic [31:0]               CpuReadData;
  logic                      CpuReadOK;
  logic                      CpuWriteOK;
  logic                      CpuFault;
  logic [ADDR_W-1:0]         SlvAddress;
  logic [31:0]               SlvWriteData;
  logic [3:0]                SlvByteEnable;
  logic [NUM_REGIONS-1:0]    SlvWriteAssert;
  logic [32*NUM_REGIONS-1:0] SlvReadData;

  modport slave (
    input  CpuAddress, CpuSize, CpuSignExtend, CpuReadAssert, CpuWriteAssert,
           CpuWriteData, SlvReadData,
    output CpuReadData, CpuReadOK, CpuWriteOK, CpuFault,
           SlvAddress, SlvWriteData, SlvByteEnable, SlvWriteAssert
  );

  modport master (
    output CpuAddress, CpuSize, CpuSignExtend, CpuReadAssert, CpuWriteAssert,
           CpuWriteData, SlvReadData,
    input  CpuReadData, CpuReadOK, CpuWriteOK, CpuFault,
           SlvAddress, SlvWriteData, SlvByteEnable, SlvWriteAssert
  );
endinterface

// File: rtl/mem_region_controller.sv
// CPU data-side controller: region decode, sub-word access, word-crossing split.
// Define MEMCTRL_MISALIGNED_EN to split crossing accesses; otherwise they fault.
module mem_region_controller #(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W      = 14,
  parameter int SEL_LSB     = 16
) (
  input  logic                   CoreClock,
  input  logic                   nReset,
  mem_region_controller_if.slave bus
);
  localparam int SEL_W     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int NUM_SLOTS = 1 << SEL_W;

`ifdef MEMCTRL_MISALIGNED_EN
  typedef enum logic {IDLE, SECOND} stateType;
`else
  typedef enum logic {IDLE} stateType;
`endif

  stateType stateReg, stateNext;

  logic                   request;
  logic [SEL_W-1:0]       cpuRegion;
  logic                   cpuValid;
  logic [ADDR_W-1:0]      cpuWord;
  logic [1:0]             offset;
  logic [2:0]             numBytes;
  logic                   crossing;
  logic [7:0]             laneMask;
  logic [63:0]            shiftedWrite;
  logic [31:0]            readWords [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   slotValid;
  logic [NUM_REGIONS-1:0] strobeVec;

  logic [ADDR_W-1:0] selWord;
  logic [SEL_W-1:0]  selRegion;
  logic [3:0]        selBe;
  logic [31:0]       selWrite;
  logic              writeEn;
  logic              okNow;
  logic              faultNow;
  logic [63:0]       readPair;
  logic [63:0]       readShifted;
  logic [31:0]       formatted;
  logic              unusedBits;

`ifdef MEMCTRL_MISALIGNED_EN
  logic [31:0]       nextAddr;
  logic [31:0]       lowBufReg, lowBufNext;
  logic [ADDR_W-1:0] secondWordReg, secondWordNext;
  logic [SEL_W-1:0]  secondRegionReg, secondRegionNext;
  logic              firstFaultReg, firstFaultNext;
  logic              secondValid;

  assign nextAddr    = bus.CpuAddress + 32'd4;
  assign secondValid = slotValid[secondRegionReg];
  assign unusedBits  = ^{bus.CpuAddress, nextAddr, readShifted[63:32]};
`else
  assign unusedBits  = ^{bus.CpuAddress, readShifted[63:32], shiftedWrite[63:32], laneMask[7:4]};
`endif

  // Pad the read mux out to a power of two so out-of-range regions read as zero.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    if (gi < NUM_REGIONS) begin : g_real
      assign readWords[gi] = bus.SlvReadData[32*gi +: 32];
      assign slotValid[gi] = 1'b1;
    end else begin : g_pad
      assign readWords[gi] = '0;
      assign slotValid[gi] = 1'b0;
    end
  end

  assign request   = bus.CpuReadAssert | bus.CpuWriteAssert;
  assign cpuRegion = bus.CpuAddress[SEL_LSB +: SEL_W];
  assign cpuValid  = slotValid[cpuRegion];
  assign cpuWord   = bus.CpuAddress[ADDR_W+1:2];
  assign offset    = bus.CpuAddress[1:0];

  always_comb begin
    numBytes = 3'd4;
    laneMask = 8'b0000_1111 << offset;
    case (bus.CpuSize)
      2'b00: begin
        numBytes = 3'd1;
        laneMask = 8'b0000_0001 << offset;
      end
      2'b01: begin
        numBytes = 3'd2;
        laneMask = 8'b0000_0011 << offset;
      end
      default: ;
    endcase
  end

  assign crossing     = ({1'b0, offset} + numBytes) > 3'd4;
  assign shiftedWrite = {32'b0, bus.CpuWriteData} << {offset, 3'b000};

  always_comb begin
    stateNext = stateReg;
    selWord   = cpuWord;
    selRegion = cpuRegion;
    selBe     = 4'b0000;
    selWrite  = shiftedWrite[31:0];
    writeEn   = 1'b0;
    okNow     = 1'b0;
    faultNow  = 1'b0;
    readPair  = '0;
`ifdef MEMCTRL_MISALIGNED_EN
    lowBufNext       = lowBufReg;
    secondWordNext   = secondWordReg;
    secondRegionNext = secondRegionReg;
    firstFaultNext   = firstFaultReg;
`endif
    case (stateReg)
      IDLE: begin
        if (request) begin
          selBe = laneMask[3:0];
          if (!crossing) begin
            writeEn  = bus.CpuWriteAssert & cpuValid;
            okNow    = 1'b1;
            faultNow = ~cpuValid;
            readPair = {32'b0, cpuValid ? readWords[cpuRegion] : 32'b0};
          end else begin
`ifdef MEMCTRL_MISALIGNED_EN
            // First half now; the fault (if any) is reported with the second half.
            writeEn          = bus.CpuWriteAssert & cpuValid;
            lowBufNext       = cpuValid ? readWords[cpuRegion] : 32'b0;
            firstFaultNext   = ~cpuValid;
            secondWordNext   = nextAddr[ADDR_W+1:2];
            secondRegionNext = nextAddr[SEL_LSB +: SEL_W];
            stateNext        = SECOND;
`else
            okNow    = 1'b1;
            faultNow = 1'b1;
`endif
          end
        end
      end
`ifdef MEMCTRL_MISALIGNED_EN
      SECOND: begin
        stateNext = IDLE;
        if (request) begin
          selWord   = secondWordReg;
          selRegion = secondRegionReg;
          selBe     = laneMask[7:4];
          selWrite  = shiftedWrite[63:32];
          writeEn   = bus.CpuWriteAssert & secondValid;
          okNow     = 1'b1;
          faultNow  = firstFaultReg | ~secondValid;
          readPair  = {secondValid ? readWords[secondRegionReg] : 32'b0, lowBufReg};
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  assign readShifted = readPair >> {offset, 3'b000};

  always_comb begin
    case (bus.CpuSize)
      2'b00:   formatted = {{24{bus.CpuSignExtend & readShifted[7]}},  readShifted[7:0]};
      2'b01:   formatted = {{16{bus.CpuSignExtend & readShifted[15]}}, readShifted[15:0]};
      default: formatted = readShifted[31:0];
    endcase
  end

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_strobe
    assign strobeVec[gi] = nReset & writeEn & (selRegion == SEL_W'(gi));
  end

  assign bus.SlvWriteAssert = strobeVec;
  assign bus.SlvAddress     = selWord;
  assign bus.SlvWriteData   = selWrite;
  assign bus.SlvByteEnable  = selBe;
  assign bus.CpuReadOK      = nReset & okNow & bus.CpuReadAssert;
  assign bus.CpuWriteOK     = nReset & okNow & bus.CpuWriteAssert;
  assign bus.CpuFault       = nReset & okNow & faultNow;
  assign bus.CpuReadData    = nReset ? formatted : 32'b0;

  always_ff @(posedge CoreClock or negedge nReset) begin
    if (!nReset) begin
      stateReg        <= IDLE;
`ifdef MEMCTRL_MISALIGNED_EN
      lowBufReg       <= '0;
      secondWordReg   <= '0;
      secondRegionReg <= '0;
      firstFaultReg   <= 1'b0;
`endif
    end else begin
      stateReg        <= stateNext;
`ifdef MEMCTRL_MISALIGNED_EN
      lowBufReg       <= lowBufNext;
      secondWordReg   <= secondWordNext;
      secondRegionReg <= secondRegionNext;
      firstFaultReg   <= firstFaultNext;
`endif
    end
  end
endmodule

// File: tb/tb_mem_region_controller.sv
// Self-checking bench for mem_region_controller with three regions and a small slave memory model.
module tb_mem_region_controller;
  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  mem_region_controller_if #(.NUM_REGIONS(3), .ADDR_W(14)) bus ();

  mem_region_controller #(.NUM_REGIONS(3), .ADDR_W(14), .SEL_LSB(16)) dut (
    .CoreClock(clk),
    .nReset   (nReset),
    .bus      (bus.slave)
  );

  // Slave model: 16 words per region, combinational read, byte-enabled write.
  logic [31:0] mem [3][16];
  logic        preWe;
  int          preR, preA;
  logic [31:0] preD;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rd
    assign bus.SlvReadData[32*gi +: 32] = mem[gi][bus.SlvAddress[3:0]];
  end

  always @(posedge clk) begin
    if (preWe) mem[preR][preA] <= preD;
    else
      for (int r = 0; r < 3; r++)
        if (bus.SlvWriteAssert[r])
          for (int b = 0; b < 4; b++)
            if (bus.SlvByteEnable[b]) mem[r][bus.SlvAddress[3:0]][8*b +: 8] <= bus.SlvWriteData[8*b +: 8];
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        eOk;
    logic        eFault;
    logic [31:0] eRdata;
    logic [2:0]  eStrobe;
    logic [13:0] eAddr;
    logic [3:0]  eBe;
    logic [31:0] eWdata;
    logic [31:0] eWmask;
    logic        chk;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t sbq[$];
  vec_t tbl[19];

  function automatic vec_t mk(logic [31:0] addr, logic [1:0] size, logic sext, logic rd, logic wr,
                              logic [31:0] wdata, logic eOk, logic eFault, logic [31:0] eRdata,
                              logic [2:0] eStrobe, logic [13:0] eAddr, logic [3:0] eBe,
                              logic [31:0] eWdata, logic [31:0] eWmask, logic chk);
    vec_t v;
    v.addr = addr; v.size = size; v.sext = sext; v.rd = rd; v.wr = wr; v.wdata = wdata;
    v.eOk = eOk; v.eFault = eFault; v.eRdata = eRdata; v.eStrobe = eStrobe; v.eAddr = eAddr;
    v.eBe = eBe; v.eWdata = eWdata; v.eWmask = eWmask; v.chk = chk;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.CpuAddress     = v.addr;
    bus.CpuSize        = v.size;
    bus.CpuSignExtend  = v.sext;
    bus.CpuReadAssert  = v.rd;
    bus.CpuWriteAssert = v.wr;
    bus.CpuWriteData   = v.wdata;
  endtask

  task automatic idle();
    bus.CpuReadAssert  = 1'b0;
    bus.CpuWriteAssert = 1'b0;
  endtask

  // Pop one expectation and compare it with this cycle's outputs, then advance a cycle.
  task automatic checkCycle(string tag);
    vec_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".rok"},    32'(bus.CpuReadOK),      32'(e.eOk & e.rd));
      chk({tag, ".wok"},    32'(bus.CpuWriteOK),     32'(e.eOk & e.wr));
      chk({tag, ".fault"},  32'(bus.CpuFault),       32'(e.eFault));
      chk({tag, ".strobe"}, 32'(bus.SlvWriteAssert), 32'(e.eStrobe));
      if (e.eOk) chk({tag, ".rdata"}, bus.CpuReadData, e.eRdata);
      if (e.chk) begin
        chk({tag, ".saddr"}, 32'(bus.SlvAddress),    32'(e.eAddr));
        chk({tag, ".be"},    32'(bus.SlvByteEnable), 32'(e.eBe));
        if (e.eWmask != 0) chk({tag, ".wdata"}, bus.SlvWriteData & e.eWmask, e.eWdata & e.eWmask);
      end
      $display("txn %s addr=%h rd=%0d wr=%0d rdata=%h ok=%0d%0d fault=%0d strobe=%b",
               tag, e.addr, e.rd, e.wr, bus.CpuReadData, bus.CpuReadOK, bus.CpuWriteOK,
               bus.CpuFault, bus.SlvWriteAssert);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single(vec_t v, string tag);
    drive(v);
    sbq.push_back(v);
    checkCycle(tag);
  endtask

  task automatic split(vec_t c1, vec_t c2, string tag);
    drive(c1);
    sbq.push_back(c1);
    sbq.push_back(c2);
    checkCycle({tag, ".c1"});
    checkCycle({tag, ".c2"});
  endtask

  task automatic pre(int r, int a, logic [31:0] d);
    preR = r; preA = a; preD = d; preWe = 1'b1;
    @(posedge clk);
    #1;
    preWe = 1'b0;
  endtask

  initial begin
    nReset = 1'b0;
    preWe  = 1'b0;
    bus.CpuAddress = '0; bus.CpuSize = 2'b10; bus.CpuSignExtend = 1'b0;
    bus.CpuWriteData = '0;
    idle();

    for (int r = 0; r < 3; r++)
      for (int a = 0; a < 16; a++) pre(r, a, 32'h0);
    pre(0, 0, 32'hAABBCCDD);
    pre(0, 1, 32'h44332211);
    pre(1, 0, 32'h80FFFFFF);
    pre(1, 1, 32'h11111111);
    pre(1, 2, 32'h8001FF7F);
    pre(1, 4, 32'h55667788);
    pre(2, 15, 32'hCAFEF00D);

    // Outputs held quiet under reset even with a request present.
    bus.CpuAddress = 32'h10; bus.CpuWriteData = 32'h5A5A5A5A;
    bus.CpuReadAssert = 1'b1; bus.CpuWriteAssert = 1'b1;
    #2;
    chk("rst.strobe", 32'(bus.SlvWriteAssert), 32'h0);
    chk("rst.rok",    32'(bus.CpuReadOK),      32'h0);
    chk("rst.wok",    32'(bus.CpuWriteOK),     32'h0);
    chk("rst.fault",  32'(bus.CpuFault),       32'h0);
    chk("rst.rdata",  bus.CpuReadData,         32'h0);
    idle();
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;

    //            addr          sz     sx    rd    wr    wdata         ok    flt   rdata         stb     saddr   be       wdata         wmask         chk
    tbl[0]  = mk(32'h00000010, 2'b10, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000, 3'b001, 14'd4,  4'b1111, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1);
    tbl[1]  = mk(32'h00000010, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 3'b000, 14'd4,  4'b1111, 32'h0,        32'h0,        1'b1);
    tbl[2]  = mk(32'h00010003, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFFFF80, 3'b000, 14'd0,  4'b1000, 32'h0,        32'h0,        1'b1);
    tbl[3]  = mk(32'h00010003, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000080, 3'b000, 14'd0,  4'b1000, 32'h0,        32'h0,        1'b1);
    tbl[4]  = mk(32'h00010008, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFFFF7F, 3'b000, 14'd2,  4'b0011, 32'h0,        32'h0,        1'b1);
    tbl[5]  = mk(32'h0001000A, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFF8001, 3'b000, 14'd2,  4'b1100, 32'h0,        32'h0,        1'b1);
    tbl[6]  = mk(32'h0001000A, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00008001, 3'b000, 14'd2,  4'b1100, 32'h0,        32'h0,        1'b1);
    tbl[7]  = mk(32'h00010009, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h000001FF, 3'b000, 14'd2,  4'b0110, 32'h0,        32'h0,        1'b1);
    tbl[8]  = mk(32'h00010008, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000007F, 3'b000, 14'd2,  4'b0001, 32'h0,        32'h0,        1'b1);
    tbl[9]  = mk(32'h00010005, 2'b00, 1'b0, 1'b0, 1'b1, 32'h000000AB, 1'b1, 1'b0, 32'h00000011, 3'b010, 14'd1,  4'b0010, 32'h0000AB00, 32'h0000FF00, 1'b1);
    tbl[10] = mk(32'h00010004, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1111AB11, 3'b000, 14'd1,  4'b1111, 32'h0,        32'h0,        1'b1);
    tbl[11] = mk(32'h0001000E, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0000BEEF, 1'b1, 1'b0, 32'h00000000, 3'b010, 14'd3,  4'b1100, 32'hBEEF0000, 32'hFFFF0000, 1'b1);
    tbl[12] = mk(32'h0001000C, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hBEEF0000, 3'b000, 14'd3,  4'b1111, 32'h0,        32'h0,        1'b1);
    tbl[13] = mk(32'h00010010, 2'b10, 1'b0, 1'b1, 1'b1, 32'h99999999, 1'b1, 1'b0, 32'h55667788, 3'b010, 14'd4,  4'b1111, 32'h99999999, 32'hFFFFFFFF, 1'b1);
    tbl[14] = mk(32'h00010010, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h99999999, 3'b000, 14'd4,  4'b1111, 32'h0,        32'h0,        1'b1);
    tbl[15] = mk(32'h00030000, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000000, 3'b000, 14'd0,  4'b1111, 32'h0,        32'h0,        1'b0);
    tbl[16] = mk(32'h00030000, 2'b10, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h00000000, 3'b000, 14'd0,  4'b1111, 32'h0,        32'h0,        1'b0);
    tbl[17] = mk(32'h0002003C, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D, 3'b000, 14'd15, 4'b1111, 32'h0,        32'h0,        1'b1);
    tbl[18] = mk(32'h00010013, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFFFF99, 3'b000, 14'd4,  4'b1000, 32'h0,        32'h0,        1'b1);

    for (int i = 0; i < 19; i++) single(tbl[i], $sformatf("v%0d", i));

`ifdef MEMCTRL_MISALIGNED_EN
    // Crossing word read across words 0/1 of region 0.
    split(mk(32'h00000003, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        3'b000, 14'd0, 4'b1000, 32'h0, 32'h0, 1'b1),
          mk(32'h00000003, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h332211AA, 3'b000, 14'd1, 4'b0111, 32'h0, 32'h0, 1'b1), "mrd");
    // Crossing word write across words 1/2 of region 0.
    split(mk(32'h00000006, 2'b10, 1'b0, 1'b0, 1'b1, 32'h11223344, 1'b0, 1'b0, 32'h0,        3'b001, 14'd1, 4'b1100, 32'h33440000, 32'hFFFF0000, 1'b1),
          mk(32'h00000006, 2'b10, 1'b0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 32'h00004433, 3'b001, 14'd2, 4'b0011, 32'h00001122, 32'h0000FFFF, 1'b1), "mwr");
    single(mk(32'h00000004, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h33442211, 3'b000, 14'd1, 4'b1111, 32'h0, 32'h0, 1'b1), "mwr.rb1");
    single(mk(32'h00000008, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00001122, 3'b000, 14'd2, 4'b1111, 32'h0, 32'h0, 1'b1), "mwr.rb2");
    // Second half lands in invalid region 3.
    split(mk(32'h0002FFFE, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        3'b000, 14'h3FFF, 4'b1100, 32'h0, 32'h0, 1'b1),
          mk(32'h0002FFFE, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000CAFE, 3'b000, 14'h3FFF, 4'b0011, 32'h0, 32'h0, 1'b0), "xrd");
    split(mk(32'h0002FFFE, 2'b10, 1'b0, 1'b0, 1'b1, 32'h01020304, 1'b0, 1'b0, 32'h0, 3'b100, 14'h3FFF, 4'b1100, 32'h03040000, 32'hFFFF0000, 1'b1),
          mk(32'h0002FFFE, 2'b10, 1'b0, 1'b0, 1'b1, 32'h01020304, 1'b1, 1'b1, 32'h0, 3'b000, 14'h3FFF, 4'b0011, 32'h0,        32'h0,        1'b0), "xwr");
    single(mk(32'h0002003C, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0304F00D, 3'b000, 14'd15, 4'b1111, 32'h0, 32'h0, 1'b1), "xwr.rb");
    // Reset during the second cycle of a split write.
    drive(mk(32'h00000019, 2'b10, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 3'b001, 14'd6, 4'b1110, 32'hA5A5A500, 32'hFFFFFF00, 1'b1));
    sbq.push_back(mk(32'h00000019, 2'b10, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 3'b001, 14'd6, 4'b1110, 32'hA5A5A500, 32'hFFFFFF00, 1'b1));
    checkCycle("mrst.c1");
`else
    single(mk(32'h00000003, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0, 3'b000, 14'd0, 4'b0, 32'h0, 32'h0, 1'b0), "mrd");
    single(mk(32'h00000006, 2'b10, 1'b0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b1, 32'h0, 3'b000, 14'd0, 4'b0, 32'h0, 32'h0, 1'b0), "mwr");
    single(mk(32'h00000004, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h44332211, 3'b000, 14'd1, 4'b1111, 32'h0, 32'h0, 1'b1), "mwr.rb1");
    single(mk(32'h0002FFFE, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 3'b000, 14'd0, 4'b0, 32'h0, 32'h0, 1'b0), "xrd");
    single(mk(32'h0002003C, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 3'b000, 14'd15, 4'b1111, 32'h0, 32'h0, 1'b1), "xwr.rb");
    single(mk(32'h00000019, 2'b10, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h0, 3'b000, 14'd0, 4'b0, 32'h0, 32'h0, 1'b0), "mrst.c1");
    drive(mk(32'h00000019, 2'b10, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 3'b000, 14'd0, 4'b0, 32'h0, 32'h0, 1'b0));
`endif
    nReset = 1'b0;
    #1;
    chk("mrst.strobe", 32'(bus.SlvWriteAssert), 32'h0);
    chk("mrst.wok",    32'(bus.CpuWriteOK),     32'h0);
    chk("mrst.fault",  32'(bus.CpuFault),       32'h0);
    chk("mrst.rdata",  bus.CpuReadData,         32'h0);
    $display("txn mrst reset asserted mid-access strobe=%b", bus.SlvWriteAssert);
    @(negedge clk);
    idle();
    nReset = 1'b1;
    @(posedge clk);
    #1;
`ifdef MEMCTRL_MISALIGNED_EN
    single(mk(32'h00000018, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA5A5A500, 3'b000, 14'd6, 4'b1111, 32'h0, 32'h0, 1'b1), "mrst.rb1");
`else
    single(mk(32'h00000018, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00000000, 3'b000, 14'd6, 4'b1111, 32'h0, 32'h0, 1'b1), "mrst.rb1");
`endif
    single(mk(32'h0000001C, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00000000, 3'b000, 14'd7, 4'b1111, 32'h0, 32'h0, 1'b1), "mrst.rb2");
    idle();

    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard.leftover actual=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
